vrf_bank_arbiter: RTL and testbench
===================================

Name: vrf_bank_arbiter

Overview:
- Shares the per-lane vector register file banks between read requesters (operand requesters) and write requesters (functional-unit and load writebacks).
- Each cycle it resolves at most one access per bank.
- Winners are driven onto the VRF bank-side request bus (req/addr/tgt_opqueue/wen/wdata/be) in the same cycle, and each winner gets a same-cycle grant.
- Sits between the lane operand requesters/writeback paths and the vector register file.

Parameters:
- NrBanks, 8, number of VRF banks; power of two, >= 2.
- NrRdReq, 4, number of read requesters.
- NrWrReq, 2, number of write requesters.
- AddrWidth, 12, requester element address width in 64-bit words across all banks.
- DataWidth, 64, bank data width (= $bits(elen_t)).
- MaxStall, 4, consecutive denied cycles before a read requester is promoted; >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- rd_req_i  in  NrRdReq  read request valid
- rd_addr_i  in  NrRdReq x AddrWidth  read word address
- rd_tgt_i  in  NrRdReq x opqueue_e  target operand queue of the read
- rd_gnt_o  out  NrRdReq  read grant (same cycle)
- wr_req_i  in  NrWrReq  write request valid
- wr_addr_i  in  NrWrReq x AddrWidth  write word address
- wr_data_i  in  NrWrReq x DataWidth  write data
- wr_be_i  in  NrWrReq x DataWidth/8  write byte enables
- wr_gnt_o  out  NrWrReq  write grant (same cycle)
- req_o  out  NrBanks  bank access request
- addr_o  out  NrBanks x (AddrWidth-log2(NrBanks))  word index inside bank
- tgt_opqueue_o  out  NrBanks x opqueue_e  target queue of the granted read
- wen_o  out  NrBanks  bank write enable
- wdata_o  out  NrBanks x DataWidth  bank write data
- be_o  out  NrBanks x DataWidth/8  bank byte enables

Behaviour:
- Bank mapping:
  - bank = addr[log2(NrBanks)-1:0]; addr_o = addr >> log2(NrBanks).
  - Each requester targets exactly one bank, so it receives at most one grant per cycle.
- Handshake:
  - Grant is combinational, in the same cycle as the request.
  - A request must hold valid with stable address, data and tgt until granted; withdrawal before grant is illegal and is checked by an assertion.
  - A request is complete in the cycle it is granted.
- Per-bank priority, highest first:
  1. Starved reads, i.e. stall_cnt == MaxStall; round-robin among them using the read pointer.
  2. Writes; round-robin using the per-bank write pointer.
  3. Reads; round-robin using the per-bank read pointer.
- Round-robin:
  - Pointer search starts at the pointer index and wraps.
  - On a grant of that class in that bank, the pointer becomes (granted index + 1) mod N.
  - With no grant of that class, the pointer holds.
- Bank outputs when a bank is granted:
  - req_o = 1, plus the winner's addr.
  - Write winner: wen_o = 1, wdata_o and be_o from the winner, tgt_opqueue_o = 0.
  - Read winner: wen_o = 0, tgt_opqueue_o = winner's rd_tgt, wdata_o and be_o = 0.
- Idle bank: all outputs of that bank are 0.
- Stall counter, one per read requester:
  - Increments, saturating at MaxStall, when rd_req_i & ~rd_gnt_o.
  - Clears to 0 on grant or when the request is low.
  - Write requesters have no counters; round-robin among writes bounds their wait.
- Reset (rst_i sampled high at the clock edge):
  - Pointers and stall counters go to 0.
  - While rst_i is high, all grants and all bank outputs are forced to 0.
  - Reset mid-operation drops in-flight requests silently; requesters re-present them after reset.
- No pipeline state other than the pointers and counters. Latency request->bank request is 0 cycles; the VRF adds its own read latency.
- Simultaneous events: a requester granted in the cycle its counter saturates clears to 0 next cycle, not to MaxStall.

Decomposition:
- ara_pkg:
  - Reuse opqueue_e.
  - Add a localparam for the bank-select width: log2 of the lane bank count.
  - Add a vrf_wr_req_t struct (addr, data, be).
- One sub-module, vrf_bank_arb_slice:
  - Per-bank combinational priority pick and pointer registers.
  - Inputs: per-requester "targets this bank" masks and the starved mask.
- The top level holds the stall counters, the bank-decode masks, the gen-for over banks and the OR-reduction of per-bank grants into rd_gnt_o/wr_gnt_o.

Test Plan (NrBanks=8, NrRdReq=4, NrWrReq=2, AddrWidth=12, MaxStall=4):
- Single read, rd0 addr=0x013, tgt=2 -> same cycle: req_o=0x08, addr_o[3]=0x002, wen_o[3]=0, tgt_opqueue_o[3]=2, rd_gnt_o=0001.
- rd0 addr=0x005 and rd1 addr=0x00D (both bank 5), re-requested after each grant for 4 cycles -> grants rd0, rd1, rd0, rd1; addr_o[5]=0x000 then 0x001 alternating.
- wr0 continuous writes to bank 1 (new addr each grant) plus rd2 held on addr=0x001 -> wr_gnt_o[0]=1 cycles 0-3, rd2 granted cycle 4 with wen_o[1]=0, wr0 granted again cycle 5, rd2 counter=0.
- wr0 addr=0x008 data=0xDEAD be=0xFF, wr1 addr=0x00F be=0x0F, rd0 addr=0x00A -> all granted same cycle: req_o=0x85, wen_o=0x81, wdata_o[0]=0xDEAD, be_o[7]=0x0F, wen_o[2]=0.
- rd0 and rd3 held on bank 6 with rst_i asserted at cycle 2 -> cycle 2 outputs all 0; after release the read pointer is 0, so rd0 wins first, then rd3.
- Bench assertions on every cycle: at most one grant per bank; every granted requester's bank has req_o=1; no grant while rst_i=1.

Source files
------------

// File: rtl/ara_pkg.sv
// Shared lane types and sizing for the VRF bank arbiter: operand-queue ids,
// bank geometry and the write-request payload.
package ara_pkg;

  localparam int unsigned NrBanks   = 8;
  localparam int unsigned NrRdReq   = 4;
  localparam int unsigned NrWrReq   = 2;
  localparam int unsigned AddrWidth = 12;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned MaxStall  = 4;

  localparam int unsigned BankSelWidth  = $clog2(NrBanks);
  localparam int unsigned BankAddrWidth = AddrWidth - BankSelWidth;
  localparam int unsigned StallWidth    = $clog2(MaxStall + 1);

  typedef enum logic [3:0] {
    AluA, AluB, AluC, MulFPUA, MulFPUB, MulFPUC,
    StA, SlideAddrGenA, MaskB, MaskM
  } opqueue_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] be;
  } vrf_wr_req_t;

endpackage

// File: rtl/vrf_bank_arb_slice.sv
// One bank's arbiter: starved reads > writes > reads, each class round-robin,
// with the per-bank read and write pointers.
module vrf_bank_arb_slice
  import ara_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrRdReq-1:0] rd_mask,
  input  logic [NrRdReq-1:0] starved,
  input  logic [NrWrReq-1:0] wr_mask,
  output logic [NrRdReq-1:0] rd_gnt,
  output logic [NrWrReq-1:0] wr_gnt
);

  localparam int unsigned RdPtrWidth = (NrRdReq > 1) ? $clog2(NrRdReq) : 1;
  localparam int unsigned WrPtrWidth = (NrWrReq > 1) ? $clog2(NrWrReq) : 1;

  logic [RdPtrWidth-1:0] rd_ptr_q, rd_ptr_d, rd_idx;
  logic [WrPtrWidth-1:0] wr_ptr_q, wr_ptr_d, wr_idx;
  logic [NrRdReq-1:0]    starved_mask;
  logic                  found;

  function automatic logic [RdPtrWidth-1:0] rd_step(logic [RdPtrWidth-1:0] p, int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NrRdReq) s = s - NrRdReq;
    return RdPtrWidth'(s);
  endfunction

  function automatic logic [WrPtrWidth-1:0] wr_step(logic [WrPtrWidth-1:0] p, int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NrWrReq) s = s - NrWrReq;
    return WrPtrWidth'(s);
  endfunction

  // Priority pick; the first class to find a candidate blocks the later ones.
  always_comb begin
    rd_gnt       = '0;
    wr_gnt       = '0;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_idx       = '0;
    wr_idx       = '0;
    found        = 1'b0;
    starved_mask = rd_mask & starved;
    for (int unsigned k = 0; k < NrRdReq; k++) begin
      rd_idx = rd_step(rd_ptr_q, k);
      if (!found && starved_mask[rd_idx]) begin
        found          = 1'b1;
        rd_gnt[rd_idx] = 1'b1;
        rd_ptr_d       = rd_step(rd_idx, 1);
      end
    end
    for (int unsigned k = 0; k < NrWrReq; k++) begin
      wr_idx = wr_step(wr_ptr_q, k);
      if (!found && wr_mask[wr_idx]) begin
        found          = 1'b1;
        wr_gnt[wr_idx] = 1'b1;
        wr_ptr_d       = wr_step(wr_idx, 1);
      end
    end
    for (int unsigned k = 0; k < NrRdReq; k++) begin
      rd_idx = rd_step(rd_ptr_q, k);
      if (!found && rd_mask[rd_idx]) begin
        found          = 1'b1;
        rd_gnt[rd_idx] = 1'b1;
        rd_ptr_d       = rd_step(rd_idx, 1);
      end
    end
    if (rst_i) begin
      rd_gnt   = '0;
      wr_gnt   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/vrf_bank_arbiter.sv
// Shares the lane VRF banks between operand-requester reads and writebacks;
// one access per bank per cycle, grants returned in the request cycle.
module vrf_bank_arbiter
  import ara_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NrRdReq-1:0]       rd_req_i,
  input  logic [AddrWidth-1:0]     rd_addr_i     [NrRdReq],
  input  opqueue_e                 rd_tgt_i      [NrRdReq],
  output logic [NrRdReq-1:0]       rd_gnt_o,
  input  logic [NrWrReq-1:0]       wr_req_i,
  input  logic [AddrWidth-1:0]     wr_addr_i     [NrWrReq],
  input  logic [DataWidth-1:0]     wr_data_i     [NrWrReq],
  input  logic [StrbWidth-1:0]     wr_be_i       [NrWrReq],
  output logic [NrWrReq-1:0]       wr_gnt_o,
  output logic [NrBanks-1:0]       req_o,
  output logic [BankAddrWidth-1:0] addr_o        [NrBanks],
  output opqueue_e                 tgt_opqueue_o [NrBanks],
  output logic [NrBanks-1:0]       wen_o,
  output logic [DataWidth-1:0]     wdata_o       [NrBanks],
  output logic [StrbWidth-1:0]     be_o          [NrBanks]
);

  logic [StallWidth-1:0] stall_cnt    [NrRdReq];
  logic [NrRdReq-1:0]    starved;
  logic [NrRdReq-1:0]    bank_rd_mask [NrBanks];
  logic [NrWrReq-1:0]    bank_wr_mask [NrBanks];
  logic [NrRdReq-1:0]    bank_rd_gnt  [NrBanks];
  logic [NrWrReq-1:0]    bank_wr_gnt  [NrBanks];
  vrf_wr_req_t           wr_req       [NrWrReq];

  // Bank decode from the low address bits.
  always_comb begin
    for (int unsigned b = 0; b < NrBanks; b++) begin
      bank_rd_mask[b] = '0;
      bank_wr_mask[b] = '0;
    end
    for (int unsigned i = 0; i < NrRdReq; i++) begin
      starved[i] = (stall_cnt[i] == StallWidth'(MaxStall));
      for (int unsigned b = 0; b < NrBanks; b++)
        bank_rd_mask[b][i] = rd_req_i[i] &&
                             (rd_addr_i[i][BankSelWidth-1:0] == BankSelWidth'(b));
    end
    for (int unsigned j = 0; j < NrWrReq; j++) begin
      wr_req[j] = '{addr: wr_addr_i[j], data: wr_data_i[j], be: wr_be_i[j]};
      for (int unsigned b = 0; b < NrBanks; b++)
        bank_wr_mask[b][j] = wr_req_i[j] &&
                             (wr_req[j].addr[BankSelWidth-1:0] == BankSelWidth'(b));
    end
  end

  for (genvar b = 0; b < NrBanks; b++) begin : gen_bank
    vrf_bank_arb_slice i_slice (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .rd_mask (bank_rd_mask[b]),
      .starved (starved),
      .wr_mask (bank_wr_mask[b]),
      .rd_gnt  (bank_rd_gnt[b]),
      .wr_gnt  (bank_wr_gnt[b])
    );
  end

  // Grants are one-hot per bank, so the winner's payload is OR-muxed.
  always_comb begin
    rd_gnt_o = '0;
    wr_gnt_o = '0;
    req_o    = '0;
    wen_o    = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      addr_o[b]        = '0;
      tgt_opqueue_o[b] = AluA;
      wdata_o[b]       = '0;
      be_o[b]          = '0;
      for (int unsigned i = 0; i < NrRdReq; i++) begin
        if (bank_rd_gnt[b][i]) begin
          rd_gnt_o[i]      = 1'b1;
          req_o[b]         = 1'b1;
          addr_o[b]        = rd_addr_i[i][AddrWidth-1:BankSelWidth];
          tgt_opqueue_o[b] = rd_tgt_i[i];
        end
      end
      for (int unsigned j = 0; j < NrWrReq; j++) begin
        if (bank_wr_gnt[b][j]) begin
          wr_gnt_o[j] = 1'b1;
          req_o[b]    = 1'b1;
          wen_o[b]    = 1'b1;
          addr_o[b]   = wr_req[j].addr[AddrWidth-1:BankSelWidth];
          wdata_o[b]  = wr_req[j].data;
          be_o[b]     = wr_req[j].be;
        end
      end
    end
  end

  // Consecutive denied cycles per read requester, saturating at MaxStall.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NrRdReq; i++) begin
      if (rst_i || !rd_req_i[i] || rd_gnt_o[i])
        stall_cnt[i] <= '0;
      else if (!starved[i])
        stall_cnt[i] <= stall_cnt[i] + StallWidth'(1);
    end
  end

  // A nonzero counter means the read was denied last cycle and must still be held.
  for (genvar i = 0; i < NrRdReq; i++) begin : gen_hold_chk
    hold_until_gnt : assert property (@(posedge clk_i) disable iff (rst_i)
      (stall_cnt[i] != '0) |-> (rd_req_i[i] && $stable(rd_addr_i[i]) && $stable(rd_tgt_i[i])));
  end

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// Self-checking bench: priority-key reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vrf_bank_arbiter;
  import ara_pkg::*;

  localparam int NB = NrBanks;
  localparam int NR = NrRdReq;
  localparam int NW = NrWrReq;
  localparam int MS = MaxStall;

  logic                     clk, rst;
  logic [NrRdReq-1:0]       rd_req;
  logic [AddrWidth-1:0]     rd_addr [NrRdReq];
  opqueue_e                 rd_tgt  [NrRdReq];
  logic [NrRdReq-1:0]       rd_gnt;
  logic [NrWrReq-1:0]       wr_req;
  logic [AddrWidth-1:0]     wr_addr [NrWrReq];
  logic [DataWidth-1:0]     wr_data [NrWrReq];
  logic [StrbWidth-1:0]     wr_be   [NrWrReq];
  logic [NrWrReq-1:0]       wr_gnt;
  logic [NrBanks-1:0]       req, wen;
  logic [BankAddrWidth-1:0] addr    [NrBanks];
  opqueue_e                 tgt     [NrBanks];
  logic [DataWidth-1:0]     wdata   [NrBanks];
  logic [StrbWidth-1:0]     be      [NrBanks];

  vrf_bank_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_tgt_i(rd_tgt), .rd_gnt_o(rd_gnt),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .wr_gnt_o(wr_gnt),
    .req_o(req), .addr_o(addr), .tgt_opqueue_o(tgt), .wen_o(wen),
    .wdata_o(wdata), .be_o(be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state and this cycle's expectations.
  int m_rd_ptr [NB];
  int m_wr_ptr [NB];
  int m_stall  [NR];
  int win_rd   [NB];
  int win_wr   [NB];
  logic [NrRdReq-1:0]       e_rd_gnt;
  logic [NrWrReq-1:0]       e_wr_gnt;
  logic [NrBanks-1:0]       e_req, e_wen;
  logic [BankAddrWidth-1:0] e_addr  [NB];
  opqueue_e                 e_tgt   [NB];
  logic [DataWidth-1:0]     e_wdata [NB];
  logic [StrbWidth-1:0]     e_be    [NB];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Each candidate gets a key: class rank*100 + rotated distance from the pointer.
  task automatic model_eval();
    e_rd_gnt = '0; e_wr_gnt = '0; e_req = '0; e_wen = '0;
    for (int b = 0; b < NB; b++) begin
      e_addr[b] = '0; e_tgt[b] = opqueue_e'(0); e_wdata[b] = '0; e_be[b] = '0;
      win_rd[b] = -1; win_wr[b] = -1;
    end
    if (rst) return;
    for (int b = 0; b < NB; b++) begin
      int best_key;
      best_key = 1000;
      for (int i = 0; i < NR; i++) begin
        if (rd_req[i] && (int'(rd_addr[i]) % NB) == b) begin
          int key;
          key = ((m_stall[i] == MS) ? 0 : 200) + (i - m_rd_ptr[b] + NR) % NR;
          if (key < best_key) begin best_key = key; win_rd[b] = i; win_wr[b] = -1; end
        end
      end
      for (int j = 0; j < NW; j++) begin
        if (wr_req[j] && (int'(wr_addr[j]) % NB) == b) begin
          int key;
          key = 100 + (j - m_wr_ptr[b] + NW) % NW;
          if (key < best_key) begin best_key = key; win_wr[b] = j; win_rd[b] = -1; end
        end
      end
      if (win_rd[b] >= 0) begin
        e_rd_gnt[win_rd[b]] = 1'b1;
        e_req[b]  = 1'b1;
        e_addr[b] = BankAddrWidth'(rd_addr[win_rd[b]] / NB);
        e_tgt[b]  = rd_tgt[win_rd[b]];
      end
      if (win_wr[b] >= 0) begin
        e_wr_gnt[win_wr[b]] = 1'b1;
        e_req[b]   = 1'b1;
        e_wen[b]   = 1'b1;
        e_addr[b]  = BankAddrWidth'(wr_addr[win_wr[b]] / NB);
        e_wdata[b] = wr_data[win_wr[b]];
        e_be[b]    = wr_be[win_wr[b]];
      end
    end
  endtask

  task automatic model_advance();
    for (int b = 0; b < NB; b++) begin
      if (rst) begin
        m_rd_ptr[b] = 0; m_wr_ptr[b] = 0;
      end else begin
        if (win_rd[b] >= 0) m_rd_ptr[b] = (win_rd[b] + 1) % NR;
        if (win_wr[b] >= 0) m_wr_ptr[b] = (win_wr[b] + 1) % NW;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (!rst && rd_req[i] && !e_rd_gnt[i])
        m_stall[i] = (m_stall[i] + 1 > MS) ? MS : m_stall[i] + 1;
      else
        m_stall[i] = 0;
    end
  endtask

  // Compare process: model vs DUT plus structural invariants, every cycle.
  always @(negedge clk) begin
    int cnt [NB];
    logic bad_multi, bad_req;
    model_eval();
    check("rd_gnt", 64'(rd_gnt), 64'(e_rd_gnt));
    check("wr_gnt", 64'(wr_gnt), 64'(e_wr_gnt));
    check("req",    64'(req),    64'(e_req));
    check("wen",    64'(wen),    64'(e_wen));
    for (int b = 0; b < NB; b++) begin
      check($sformatf("addr[%0d]", b),  64'(addr[b]),  64'(e_addr[b]));
      check($sformatf("tgt[%0d]", b),   64'(tgt[b]),   64'(e_tgt[b]));
      check($sformatf("wdata[%0d]", b), 64'(wdata[b]), 64'(e_wdata[b]));
      check($sformatf("be[%0d]", b),    64'(be[b]),    64'(e_be[b]));
      cnt[b] = 0;
    end
    bad_multi = 1'b0;
    bad_req   = 1'b0;
    for (int i = 0; i < NR; i++)
      if (rd_gnt[i]) begin
        cnt[int'(rd_addr[i]) % NB]++;
        if (!req[int'(rd_addr[i]) % NB]) bad_req = 1'b1;
      end
    for (int j = 0; j < NW; j++)
      if (wr_gnt[j]) begin
        cnt[int'(wr_addr[j]) % NB]++;
        if (!req[int'(wr_addr[j]) % NB]) bad_req = 1'b1;
      end
    for (int b = 0; b < NB; b++) if (cnt[b] > 1) bad_multi = 1'b1;
    check("one_grant_per_bank", 64'(bad_multi), 64'(0));
    check("granted_bank_req",   64'(bad_req),   64'(0));
    check("no_grant_in_reset",  64'(rst && ((|rd_gnt) || (|wr_gnt))), 64'(0));
    model_advance();
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point();
    @(negedge clk);
    #1;
  endtask

  task automatic drop_granted();
    for (int i = 0; i < NR; i++) if (e_rd_gnt[i]) rd_req[i] = 1'b0;
    for (int j = 0; j < NW; j++) if (e_wr_gnt[j]) wr_req[j] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && ((|rd_req) || (|wr_req)); k++) begin
      next_cycle();
      drop_granted();
    end
    if ((|rd_req) || (|wr_req)) begin
      check("drain_timeout", 64'(1), 64'(0));
      rd_req = '0;
      wr_req = '0;
    end
  endtask

  function automatic logic [AddrWidth-1:0] rand_addr();
    logic [AddrWidth-1:0] a;
    a = AddrWidth'($urandom);
    if ($urandom_range(0, 1) == 1) a[2] = 1'b0;
    return a;
  endfunction

  task automatic rand_cycle();
    logic prev_rst;
    next_cycle();
    prev_rst = rst;
    for (int i = 0; i < NR; i++) begin
      if (rd_req[i] && (e_rd_gnt[i] || prev_rst)) rd_req[i] = 1'b0;
      if (!rd_req[i] && $urandom_range(0, 1) == 1) begin
        rd_req[i]  = 1'b1;
        rd_addr[i] = rand_addr();
        rd_tgt[i]  = opqueue_e'($urandom_range(0, 9));
      end
    end
    for (int j = 0; j < NW; j++) begin
      if (wr_req[j] && (e_wr_gnt[j] || prev_rst)) wr_req[j] = 1'b0;
      if (!wr_req[j] && $urandom_range(0, 1) == 1) begin
        wr_req[j]  = 1'b1;
        wr_addr[j] = rand_addr();
        wr_data[j] = {$urandom, $urandom};
        wr_be[j]   = StrbWidth'($urandom);
      end
    end
    rst = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; rd_req = '0; wr_req = '0;
    for (int i = 0; i < NR; i++) begin rd_addr[i] = '0; rd_tgt[i] = opqueue_e'(0); end
    for (int j = 0; j < NW; j++) begin wr_addr[j] = '0; wr_data[j] = '0; wr_be[j] = '0; end
    repeat (3) next_cycle();
    rst = 1'b0;
    sample_point();
    check("idle_req", 64'(req), 64'(0));

    // Single read to bank 3.
    next_cycle();
    rd_req[0] = 1'b1; rd_addr[0] = 12'h013; rd_tgt[0] = opqueue_e'(2);
    sample_point();
    check("t1_req",    64'(req),    64'h08);
    check("t1_addr3",  64'(addr[3]), 64'h002);
    check("t1_wen3",   64'(wen[3]),  64'(0));
    check("t1_tgt3",   64'(tgt[3]),  64'(2));
    check("t1_rd_gnt", 64'(rd_gnt),  64'b0001);
    drain();

    // Two reads sharing bank 5 alternate.
    next_cycle();
    rd_req[0] = 1'b1; rd_addr[0] = 12'h005;
    rd_req[1] = 1'b1; rd_addr[1] = 12'h00D;
    for (int c = 0; c < 4; c++) begin
      sample_point();
      check("t2_rd_gnt", 64'(rd_gnt),  (c % 2 == 0) ? 64'b0001 : 64'b0010);
      check("t2_addr5",  64'(addr[5]), 64'(c % 2));
      next_cycle();
    end
    drain();

    // Continuous writes starve rd2 until it is promoted.
    next_cycle();
    k = 0;
    wr_req[0] = 1'b1; wr_addr[0] = 12'h001; wr_data[0] = 64'h1111; wr_be[0] = 8'hFF;
    rd_req[2] = 1'b1; rd_addr[2] = 12'h001; rd_tgt[2] = opqueue_e'(5);
    for (int c = 0; c < 6; c++) begin
      sample_point();
      check("t3_wr_gnt", 64'(wr_gnt), (c == 4) ? 64'b00 : 64'b01);
      check("t3_rd_gnt", 64'(rd_gnt), (c == 4) ? 64'b0100 : 64'b0000);
      if (c == 4) check("t3_wen1", 64'(wen[1]), 64'(0));
      next_cycle();
      drop_granted();
      if (c < 5 && !wr_req[0]) begin
        k++;
        wr_req[0] = 1'b1; wr_addr[0] = AddrWidth'(12'h001 + 8 * k); wr_data[0] = 64'(k);
      end
    end
    drain();

    // Three banks served in the same cycle.
    next_cycle();
    wr_req = 2'b11;
    wr_addr[0] = 12'h008; wr_data[0] = 64'hDEAD; wr_be[0] = 8'hFF;
    wr_addr[1] = 12'h00F; wr_data[1] = 64'hBEEF; wr_be[1] = 8'h0F;
    rd_req[0] = 1'b1; rd_addr[0] = 12'h00A; rd_tgt[0] = opqueue_e'(1);
    sample_point();
    check("t4_req",    64'(req),      64'h85);
    check("t4_wen",    64'(wen),      64'h81);
    check("t4_wdata0", 64'(wdata[0]), 64'hDEAD);
    check("t4_be7",    64'(be[7]),    64'h0F);
    check("t4_wen2",   64'(wen[2]),   64'(0));
    check("t4_gnts",   64'({wr_gnt, rd_gnt}), 64'b11_0001);
    drain();

    // Reset in the middle of a bank-6 contention.
    next_cycle();
    rd_req[0] = 1'b1; rd_addr[0] = 12'h006;
    rd_req[3] = 1'b1; rd_addr[3] = 12'h00E;
    sample_point();
    check("t5_c0", 64'(rd_gnt), 64'b0001);
    next_cycle();
    sample_point();
    check("t5_c1", 64'(rd_gnt), 64'b1000);
    next_cycle();
    rst = 1'b1;
    sample_point();
    check("t5_rst_req",  64'(req),     64'(0));
    check("t5_rst_gnt",  64'(rd_gnt),  64'(0));
    check("t5_rst_addr", 64'(addr[6]), 64'(0));
    next_cycle();
    rst = 1'b0;
    sample_point();
    check("t5_c3", 64'(rd_gnt), 64'b0001);
    next_cycle();
    drop_granted();
    sample_point();
    check("t5_c4", 64'(rd_gnt), 64'b1000);
    drain();

    // Randomized traffic, checked by the compare process.
    for (int c = 0; c < 3000; c++) rand_cycle();
    next_cycle();
    rst = 1'b1;
    rd_req = '0;
    wr_req = '0;
    next_cycle();
    sample_point();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
